// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer wrapped around an external combinational ALU.
// Accepts one instruction, drives registered operands for one cycle, writes the ALU result back.
module alu_issue_ctrl #(
  parameter int unsigned DW   = 4,
  parameter int unsigned NREG = 4,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_ra,
  input  logic [AW-1:0] in_rb,
  input  logic [DW-1:0] in_imm,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_sel,
  input  logic [DW-1:0] alu_y,
  input  logic          alu_carry,
  output logic          done_valid,
  output logic [DW-1:0] done_data,
  output logic          carry_flag,
  output logic          zero_flag,
  output logic          err,
  input  logic          err_clr,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b101;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [2:0]    op;
    logic [DW-1:0] imm;
  } instr_t;

  logic [0:0]    state, state_d;
  instr_t        instr, instr_d;
  logic [DW-1:0] rf [NREG];
  logic [DW-1:0] rf_d [NREG];
  logic [DW-1:0] alu_a_d, alu_b_d, done_data_d, wb_val;
  logic [2:0]    alu_sel_d;
  logic          done_valid_d, carry_flag_d, zero_flag_d, err_d;
  logic          accept, illegal;

  assign in_ready = (state == S_IDLE);
  assign dbg_data = rf[dbg_addr];
  assign accept   = in_valid && in_ready;
  assign illegal  = (in_op[2:1] == 2'b11);

  // Next-state and next-register computation
  always_comb begin
    state_d      = state;
    instr_d      = instr;
    rf_d         = rf;
    alu_a_d      = alu_a;
    alu_b_d      = alu_b;
    alu_sel_d    = alu_sel;
    done_valid_d = 1'b0;
    done_data_d  = done_data;
    carry_flag_d = carry_flag;
    zero_flag_d  = zero_flag;
    err_d        = err_clr ? 1'b0 : err;
    wb_val       = '0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          if (illegal) begin
            // set wins over a simultaneous clear
            err_d = 1'b1;
          end else begin
            alu_a_d    = rf[in_ra];
            alu_b_d    = rf[in_rb];
            alu_sel_d  = (in_op == OP_LDI) ? OP_ADD : in_op;
            instr_d.rd  = in_rd;
            instr_d.op  = in_op;
            instr_d.imm = in_imm;
            state_d    = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        wb_val            = (instr.op == OP_LDI) ? instr.imm : alu_y;
        rf_d[instr.rd]    = wb_val;
        carry_flag_d      = (instr.op == OP_LDI) ? 1'b0 : alu_carry;
        zero_flag_d       = (wb_val == '0);
        done_data_d       = wb_val;
        done_valid_d      = 1'b1;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      instr      <= '0;
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      done_valid <= 1'b0;
      done_data  <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      instr      <= instr_d;
      for (int i = 0; i < int'(NREG); i++) rf[i] <= rf_d[i];
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      alu_sel    <= alu_sel_d;
      done_valid <= done_valid_d;
      done_data  <= done_data_d;
      carry_flag <= carry_flag_d;
      zero_flag  <= zero_flag_d;
      err        <= err_d;
    end
  end

endmodule
